// File: rtl/ntt_bf_sequencer.sv
// Kyber NTT/INTT control engine: walks 7 layers x 128 butterflies, feeding one
// butterfly unit from the coefficient RAM/twiddle ROM and writing results back in place.
module ntt_bf_sequencer #(
    parameter int BF_LAT   = 4,
    parameter int N_LAYERS = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rd_addr_a,
    output logic [7:0]  rd_addr_b,
    input  logic [11:0] rd_data_a,
    input  logic [11:0] rd_data_b,
    output logic [6:0]  tw_addr,
    input  logic [11:0] tw_data,
    output logic        bf_ct,
    output logic [11:0] bf_a,
    output logic [11:0] bf_b,
    output logic [11:0] bf_w,
    input  logic [11:0] bf_e,
    input  logic [11:0] bf_o,
    output logic        wr_en,
    output logic [7:0]  wr_addr_e,
    output logic [7:0]  wr_addr_o,
    output logic [11:0] wr_data_e,
    output logic [11:0] wr_data_o
);

    localparam int         LAT        = BF_LAT + 3;
    localparam logic [2:0] LAST_LAYER = 3'(N_LAYERS - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]     state_r;
    logic           mode_r;
    logic           first_r;
    logic           iss_r;
    logic           busy_r;
    logic           done_r;
    logic           bf_ct_r;
    logic [2:0]     layer_r;
    logic [6:0]     idx_r;
    logic [6:0]     tw_addr_r;
    logic [7:0]     rd_addr_a_r;
    logic [7:0]     rd_addr_b_r;
    logic [LAT-1:1] vld_r;
    logic [7:0]     ea_pipe_r [1:LAT-1];
    logic [7:0]     ob_pipe_r [1:LAT-1];
    logic [11:0]    bf_a_r;
    logic [11:0]    bf_b_r;
    logic [11:0]    bf_w_r;
    logic           wr_en_r;
    logic [7:0]     wr_addr_e_r;
    logic [7:0]     wr_addr_o_r;
    logic [11:0]    wr_data_e_r;
    logic [11:0]    wr_data_o_r;

    logic [2:0]     sh_s;
    logic [7:0]     len_s;
    logic [7:0]     mask_s;
    logic [7:0]     idx8_s;
    logic [7:0]     addr_a_s;
    logic [7:0]     addr_b_s;
    logic           off_zero_s;
    logic [6:0]     k_step_s;
    logic           pipe_empty_s;

    // Butterfly address and twiddle step for the current (layer, index)
    always_comb begin
        sh_s         = mode_r ? (layer_r + 3'd1) : (3'd7 - layer_r);
        len_s        = 8'd1 << sh_s;
        mask_s       = len_s - 8'd1;
        idx8_s       = {1'b0, idx_r};
        // len is a power of two: group bits move up one place, offset bits stay
        addr_a_s     = ((idx8_s & ~mask_s) << 3'd1) | (idx8_s & mask_s);
        addr_b_s     = addr_a_s | len_s;
        off_zero_s   = ((idx8_s & mask_s) == 8'd0);
        k_step_s     = mode_r ? (tw_addr_r - 7'd1) : (tw_addr_r + 7'd1);
        // the oldest issue may still be in its write stage; it commits before the next read
        pipe_empty_s = !iss_r && (vld_r[LAT-2:1] == {(LAT-2){1'b0}});
    end

    // Sequencing FSM, issue registers and twiddle counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            mode_r      <= 1'b0;
            first_r     <= 1'b0;
            iss_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            bf_ct_r     <= 1'b1;
            layer_r     <= 3'd0;
            idx_r       <= 7'd0;
            tw_addr_r   <= 7'd0;
            rd_addr_a_r <= 8'd0;
            rd_addr_b_r <= 8'd0;
        end else begin
            iss_r  <= (state_r == ST_RUN);
            done_r <= (state_r == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        mode_r    <= mode;
                        bf_ct_r   <= ~mode;
                        busy_r    <= 1'b1;
                        layer_r   <= 3'd0;
                        idx_r     <= 7'd0;
                        first_r   <= 1'b1;
                        tw_addr_r <= mode ? 7'd127 : 7'd1;
                        state_r   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    rd_addr_a_r <= addr_a_s;
                    rd_addr_b_r <= addr_b_s;
                    if (off_zero_s && !first_r) begin
                        tw_addr_r <= k_step_s;
                    end
                    first_r <= 1'b0;
                    idx_r   <= idx_r + 7'd1;
                    if (idx_r == 7'd127) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pipe_empty_s) begin
                        if (layer_r == LAST_LAYER) begin
                            state_r <= ST_DONE;
                        end else begin
                            layer_r <= layer_r + 3'd1;
                            state_r <= ST_RUN;
                        end
                    end
                end
                ST_DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Operand capture, write-address delay line and write-back registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_r       <= {(LAT-1){1'b0}};
            bf_a_r      <= 12'd0;
            bf_b_r      <= 12'd0;
            bf_w_r      <= 12'd0;
            wr_en_r     <= 1'b0;
            wr_addr_e_r <= 8'd0;
            wr_addr_o_r <= 8'd0;
            wr_data_e_r <= 12'd0;
            wr_data_o_r <= 12'd0;
            for (int j = 1; j < LAT; j++) begin
                ea_pipe_r[j] <= 8'd0;
                ob_pipe_r[j] <= 8'd0;
            end
        end else begin
            vld_r        <= {vld_r[LAT-2:1], iss_r};
            ea_pipe_r[1] <= rd_addr_a_r;
            ob_pipe_r[1] <= rd_addr_b_r;
            for (int j = 2; j < LAT; j++) begin
                ea_pipe_r[j] <= ea_pipe_r[j-1];
                ob_pipe_r[j] <= ob_pipe_r[j-1];
            end
            if (vld_r[1]) begin
                bf_a_r <= rd_data_a;
                bf_b_r <= rd_data_b;
                bf_w_r <= tw_data;
            end
            wr_en_r <= vld_r[LAT-1];
            if (vld_r[LAT-1]) begin
                wr_addr_e_r <= ea_pipe_r[LAT-1];
                wr_addr_o_r <= ob_pipe_r[LAT-1];
                wr_data_e_r <= bf_e;
                wr_data_o_r <= bf_o;
            end
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign rd_addr_a = rd_addr_a_r;
    assign rd_addr_b = rd_addr_b_r;
    assign tw_addr   = tw_addr_r;
    assign bf_ct     = bf_ct_r;
    assign bf_a      = bf_a_r;
    assign bf_b      = bf_b_r;
    assign bf_w      = bf_w_r;
    assign wr_en     = wr_en_r;
    assign wr_addr_e = wr_addr_e_r;
    assign wr_addr_o = wr_addr_o_r;
    assign wr_data_e = wr_data_e_r;
    assign wr_data_o = wr_data_o_r;

endmodule

// File: tb/tb_ntt_bf_sequencer.sv
// Bench for ntt_bf_sequencer: behavioural RAM/ROM/butterfly around the DUT, golden
// Kyber NTT from plain loops, and an address/timing schedule derived from the layer formulas.
module tb_ntt_bf_sequencer;

    localparam int BF_LAT = 4;
    localparam int L      = BF_LAT + 3;
    localparam int LC     = 128 + L;
    localparam int Q      = 3329;
    localparam int MAXC   = 1100;

    logic        clk, rst, start, mode, busy, done, bf_ct, wr_en, load;
    logic [7:0]  rd_addr_a, rd_addr_b, wr_addr_e, wr_addr_o;
    logic [11:0] rd_data_a, rd_data_b, tw_data, bf_a, bf_b, bf_w, bf_e, bf_o;
    logic [11:0] wr_data_e, wr_data_o;
    logic [6:0]  tw_addr;

    int n_vec, n_err;
    int zetas[128];
    int ram[256];
    int img[256];
    int orig[256];
    int gold[256];
    int h_ra[MAXC], h_rb[MAXC], h_tw[MAXC], h_we[MAXC], h_wae[MAXC], h_wao[MAXC];
    int h_done[MAXC], h_busy[MAXC], h_ct[MAXC];
    int e_we[MAXC], e_wa[MAXC], e_wb[MAXC];
    int nrec, cur_c;
    logic [11:0] pe[BF_LAT];
    logic [11:0] po[BF_LAT];

    ntt_bf_sequencer #(.BF_LAT(BF_LAT), .N_LAYERS(7)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .busy(busy), .done(done),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .tw_addr(tw_addr), .tw_data(tw_data), .bf_ct(bf_ct), .bf_a(bf_a), .bf_b(bf_b), .bf_w(bf_w),
        .bf_e(bf_e), .bf_o(bf_o), .wr_en(wr_en), .wr_addr_e(wr_addr_e), .wr_addr_o(wr_addr_o),
        .wr_data_e(wr_data_e), .wr_data_o(wr_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int mulq(input int x, input int y);
        return (x * y) % Q;
    endfunction

    function automatic int bfe_fn(input int a, input int b, input int w, input logic ct);
        if (ct) return (a + mulq(w, b)) % Q;
        return mulq((a + b) % Q, 1665);
    endfunction

    function automatic int bfo_fn(input int a, input int b, input int w, input logic ct);
        if (ct) return (a - mulq(w, b) + Q) % Q;
        return mulq(mulq(w, (b - a + Q) % Q), 1665);
    endfunction

    // coefficient RAM (2R/2W) and twiddle ROM, both with one-cycle read latency
    always @(posedge clk) begin
        rd_data_a <= 12'(ram[rd_addr_a]);
        rd_data_b <= 12'(ram[rd_addr_b]);
        tw_data   <= 12'(zetas[tw_addr]);
        if (load) begin
            for (int i = 0; i < 256; i++) ram[i] = img[i];
        end else if (wr_en) begin
            ram[wr_addr_e] = int'(wr_data_e);
            ram[wr_addr_o] = int'(wr_data_o);
        end
    end

    // butterfly unit with BF_LAT cycles of pipeline
    always @(posedge clk) begin
        pe[0] <= 12'(bfe_fn(int'(bf_a), int'(bf_b), int'(bf_w), bf_ct));
        po[0] <= 12'(bfo_fn(int'(bf_a), int'(bf_b), int'(bf_w), bf_ct));
        for (int j = 1; j < BF_LAT; j++) begin
            pe[j] <= pe[j-1];
            po[j] <= po[j-1];
        end
    end
    assign bf_e = pe[BF_LAT-1];
    assign bf_o = po[BF_LAT-1];

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic ref_ntt();
        int k, z, t;
        k = 1;
        for (int len = 128; len >= 2; len = len / 2) begin
            for (int st = 0; st < 256; st += 2 * len) begin
                z = zetas[k];
                k++;
                for (int j = st; j < st + len; j++) begin
                    t = mulq(z, gold[j + len]);
                    gold[j + len] = (gold[j] - t + Q) % Q;
                    gold[j] = (gold[j] + t) % Q;
                end
            end
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 256; i++) begin
            img[i]  = int'($urandom_range(Q - 1, 0));
            orig[i] = img[i];
            gold[i] = img[i];
        end
        ref_ntt();
        @(negedge clk) load = 1'b1;
        @(negedge clk) load = 1'b0;
    endtask

    task automatic run_op(input logic m, input int pulse_at, input string pfx);
        int seen;
        seen = 0;
        nrec = 0;
        mode = m;
        start = 1'b1;
        for (int cyc = 0; cyc < MAXC && seen == 0; cyc++) begin
            @(negedge clk);
            h_ra[cyc] = int'(rd_addr_a);  h_rb[cyc] = int'(rd_addr_b);  h_tw[cyc] = int'(tw_addr);
            h_we[cyc] = int'(wr_en);      h_wae[cyc] = int'(wr_addr_e); h_wao[cyc] = int'(wr_addr_o);
            h_done[cyc] = int'(done);     h_busy[cyc] = int'(busy);     h_ct[cyc] = int'(bf_ct);
            nrec = cyc + 1;
            if (done) seen = 1;
            start = (cyc == pulse_at);
            mode  = (cyc == pulse_at) ? ~m : m;
        end
        start = 1'b0;
        check_eq({pfx, "_done_seen"}, seen, 1);
    endtask

    task automatic spot(input string pfx, input int l, input int i, input int ea, input int eb, input int ek);
        int t;
        t = cur_c + l * LC + i;
        if (t >= MAXC) t = MAXC - 1;
        check_eq($sformatf("%s_L%0d_i%0d_addr_a", pfx, l, i), h_ra[t], ea);
        check_eq($sformatf("%s_L%0d_i%0d_addr_b", pfx, l, i), h_rb[t], eb);
        check_eq($sformatf("%s_L%0d_i%0d_tw", pfx, l, i), h_tw[t], ek);
    endtask

    task automatic analyse(input logic m, input string pfx);
        int fw, c, len, g, a, b, k, t, td;
        int addr_err, tw_err, we_err, wa_err, fwd_err, done_err, busy_err, early;
        fw = -1;
        addr_err = 0; tw_err = 0; we_err = 0; wa_err = 0; fwd_err = 0;
        done_err = 0; busy_err = 0; early = 0;
        for (int cyc = 0; cyc < nrec; cyc++) if (h_we[cyc] == 1 && fw < 0) fw = cyc;
        check_eq({pfx, "_first_write_found"}, (fw >= L) ? 1 : 0, 1);
        c = (fw >= L) ? fw - L : 0;
        cur_c = c;
        for (int cyc = 0; cyc < MAXC; cyc++) begin
            e_we[cyc] = 0; e_wa[cyc] = 0; e_wb[cyc] = 0;
        end
        for (int l = 0; l < 7; l++) begin
            len = m ? (2 << l) : (128 >> l);
            for (int i = 0; i < 128; i++) begin
                g = i / len;
                a = 2 * g * len + (i % len);
                b = a + len;
                k = m ? ((128 >> l) - 1 - g) : ((1 << l) + g);
                t = c + l * LC + i;
                if (t < nrec) begin
                    if (h_ra[t] != a || h_rb[t] != b) addr_err++;
                    if (h_tw[t] != k) tw_err++;
                end
                if (t + L < MAXC) begin
                    e_we[t + L] = 1; e_wa[t + L] = a; e_wb[t + L] = b;
                end
            end
            for (int j = 0; j < L; j++) if (c + l * LC + j < nrec && h_we[c + l * LC + j] == 1) early++;
        end
        td = c + 945;
        for (int cyc = 0; cyc < nrec; cyc++) begin
            if (h_we[cyc] != e_we[cyc]) we_err++;
            if (e_we[cyc] == 1 && (h_wae[cyc] != e_wa[cyc] || h_wao[cyc] != e_wb[cyc])) wa_err++;
            if (h_we[cyc] == 1 && cyc >= L && (h_wae[cyc] != h_ra[cyc - L] || h_wao[cyc] != h_rb[cyc - L])) fwd_err++;
            if (h_done[cyc] != ((cyc == td) ? 1 : 0)) done_err++;
            if (h_busy[cyc] != ((cyc < td) ? 1 : 0)) busy_err++;
        end
        check_eq({pfx, "_rd_addr_errs"}, addr_err, 0);
        check_eq({pfx, "_tw_errs"}, tw_err, 0);
        check_eq({pfx, "_wr_en_errs"}, we_err, 0);
        check_eq({pfx, "_wr_addr_errs"}, wa_err, 0);
        check_eq({pfx, "_wr_vs_rd_L_earlier"}, fwd_err, 0);
        check_eq({pfx, "_early_writes"}, early, 0);
        check_eq({pfx, "_done_errs"}, done_err, 0);
        check_eq({pfx, "_busy_errs"}, busy_err, 0);
        check_eq({pfx, "_done_latency"}, nrec - 1 - c, 945);
        check_eq({pfx, "_bf_ct"}, h_ct[c], m ? 0 : 1);
    endtask

    task automatic check_ram(input string tag, input logic vs_orig);
        int bad;
        bad = 0;
        for (int i = 0; i < 256; i++) if (ram[i] != (vs_orig ? orig[i] : gold[i])) bad++;
        check_eq(tag, bad, 0);
    endtask

    initial begin
        int br, z;
        n_vec = 0; n_err = 0; load = 1'b0;
        for (int k = 0; k < 128; k++) begin
            br = 0;
            for (int bt = 0; bt < 7; bt++) if (((k >> bt) & 1) == 1) br |= (1 << (6 - bt));
            z = 1;
            for (int e = 0; e < br; e++) z = mulq(z, 17);
            zetas[k] = z;
        end
        rst = 1'b0; start = 1'b1; mode = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_wr_en", int'(wr_en), 0);
        check_eq("rst_rd_addr_a", int'(rd_addr_a), 0);
        check_eq("rst_rd_addr_b", int'(rd_addr_b), 0);
        check_eq("rst_tw_addr", int'(tw_addr), 0);
        check_eq("rst_wr_addr_e", int'(wr_addr_e), 0);
        check_eq("rst_bf_ct", int'(bf_ct), 1);
        check_eq("rst_bf_a", int'(bf_a), 0);
        start = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(negedge clk);

        // forward NTT, with an ignored start pulse (and mode flip) mid-run
        fill_random();
        run_op(1'b0, 300, "ntt");
        analyse(1'b0, "ntt");
        spot("ntt", 0, 0, 0, 128, 1);
        spot("ntt", 0, 127, 127, 255, 1);
        spot("ntt", 1, 64, 128, 192, 3);
        spot("ntt", 6, 2, 4, 6, 65);
        spot("ntt", 6, 127, 253, 255, 127);
        check_ram("ntt_result_vs_golden", 1'b0);

        // inverse NTT on that result recovers the input
        @(negedge clk);
        run_op(1'b1, -1, "intt");
        analyse(1'b1, "intt");
        spot("intt", 0, 0, 0, 2, 127);
        spot("intt", 0, 2, 4, 6, 126);
        spot("intt", 6, 0, 0, 128, 1);
        spot("intt", 6, 127, 127, 255, 1);
        check_ram("intt_recovers_input", 1'b1);

        // asynchronous reset in the middle of layer 3
        fill_random();
        mode = 1'b0; start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (3 * LC + 60) @(negedge clk);
        check_eq("pre_rst_wr_en", int'(wr_en), 1);
        check_eq("pre_rst_busy", int'(busy), 1);
        rst = 1'b0;
        #1;
        check_eq("async_rst_wr_en", int'(wr_en), 0);
        check_eq("async_rst_busy", int'(busy), 0);
        check_eq("async_rst_done", int'(done), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        fill_random();
        run_op(1'b0, -1, "ntt2");
        analyse(1'b0, "ntt2");
        check_ram("ntt2_result_vs_golden", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ntt_bf_sequencer.md
Name: ntt_bf_sequencer

Overview:
- Control/address engine that drives one Kyber butterfly unit (q=3329, n=256, 12-bit coefficients) through a complete 7-layer forward NTT (CT) or inverse NTT (GS).
- Reads coefficient pairs from a two-read/two-write coefficient RAM and twiddles from a ROM, issues them to the butterfly, and writes the E/O results back to the same addresses.
- Sits between the polynomial memory and the butterfly datapath; it initiates every butterfly transaction.

Parameters:
- BF_LAT, 4: cycles from bf_a/bf_b/bf_w presented to bf_e/bf_o valid (butterfly pipeline depth).
- N_LAYERS, 7: number of NTT layers. Fixed for Kyber; do not change.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  one-cycle request; sampled only in IDLE.
- mode  in  1  0 = forward NTT (CT), 1 = inverse NTT (GS); latched on accepted start.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse after the final write-back.
- rd_addr_a  out  8  coefficient RAM read address, even (A) operand.
- rd_addr_b  out  8  coefficient RAM read address, odd (B) operand.
- rd_data_a  in  12  RAM read data; 1-cycle read latency.
- rd_data_b  in  12  RAM read data; 1-cycle read latency.
- tw_addr  out  7  twiddle ROM address.
- tw_data  in  12  twiddle ROM data; 1-cycle read latency.
- bf_ct  out  1  butterfly CT select = ~latched mode; constant while busy.
- bf_a  out  12  registered butterfly operand A.
- bf_b  out  12  registered butterfly operand B.
- bf_w  out  12  registered butterfly twiddle W.
- bf_e  in  12  butterfly output E.
- bf_o  in  12  butterfly output O.
- wr_en  out  1  write strobe, both write ports.
- wr_addr_e  out  8  write address for E.
- wr_addr_o  out  8  write address for O.
- wr_data_e  out  12  registered copy of bf_e.
- wr_data_o  out  12  registered copy of bf_o.

Behaviour:
- Reset: state IDLE; all outputs 0, except bf_ct = 1 (latched mode = 0). Reset takes effect asynchronously at any time, including mid-run: wr_en, busy and done drop immediately and any in-flight butterflies are discarded.
- States:
  - IDLE: on start=1, latch mode, go to RUN, set busy.
  - RUN: issue one butterfly per cycle for i = 0..127, then go to DRAIN.
  - DRAIN: wait until the in-flight valid pipe is empty. Then go to RUN for the next layer, or to DONE after the last layer.
  - DONE: assert done for one cycle, clear busy, return to IDLE.
- Addressing for layer l (0..6) and butterfly i:
  - NTT: len = 128 >> l. INTT: len = 2 << l.
  - g = i / len; off = i mod len.
  - rd_addr_a = 2·g·len + off; rd_addr_b = rd_addr_a + len.
- Twiddle counter k:
  - Set to 1 (NTT) or 127 (INTT) on start.
  - Step +1 (NTT) or −1 (INTT) at every group boundary, i.e. when off wraps to 0, except the very first issue of the run.
  - tw_addr = k.
- Pipeline timing, with issue at cycle t:
  - RAM/ROM data arrive at t+1.
  - bf_a/bf_b/bf_w are registered and valid at t+2.
  - bf_e/bf_o are valid at t+2+BF_LAT.
  - wr_data and wr_en are registered at t+3+BF_LAT.
  - Write addresses travel down a (BF_LAT+3)-deep delay line together with a valid bit.
- Round-trip latency: L = BF_LAT+3.
- Layer timing:
  - A layer whose first issue is at cycle c has its last issue at c+127 and its last write at c+127+L.
  - The next layer's first issue is at c+128+L, so all reads follow committed writes and no RAW hazard is possible.
  - done is asserted at c+128+L of the last layer.
  - Total from first issue to done = 7·(128+L), which is 945 cycles at BF_LAT=4.
- bf_a/bf_b/bf_w hold their last value when no issue is in flight. wr_en = 0 except on valid write cycles.
- start during busy or DONE is ignored. start held high re-triggers on the first IDLE cycle after done.
- mode changes while busy are ignored.
- No final n⁻¹ scaling pass: the butterfly's GS halving provides the 1/128 factor.

Test Plan:
- Reset: hold rst=0 with start=1 → busy=0, done=0, wr_en=0, all addresses 0.
- NTT address trace (mode=0):
  - Layer 0: i=0 → (0,128) with tw 1; i=127 → (127,255) with tw 1.
  - Layer 1: i=64 → (128,192) with tw 3.
  - Layer 6: i=2 → (4,6) with tw 65; last issue uses tw 127.
- INTT address trace (mode=1):
  - Layer 0: i=0 → (0,2) with tw 127; i=2 → (4,6) with tw 126.
  - Layer 6: every issue uses tw 1.
- Full run with a behavioural butterfly model (BF_LAT=4), random input: NTT result matches golden Kyber NTT; done arrives exactly 945 cycles after the first issue. Running INTT on that result recovers the original polynomial.
- Protocol: start pulse during RUN is ignored; no write occurs in the first L cycles of each layer; wr_addr_e equals the rd_addr_a issued L cycles earlier.
- Async reset asserted mid layer 3 → wr_en and busy are 0 the same cycle. A subsequent start completes a clean full NTT matching golden.
